// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle RV32M divider (DIV/DIVU/REM/REMU) writing into the register file port
// Optional EX_DIV_EARLY_OUT_EN: finish in one step when |divisor| > |dividend|.
module ex_div #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic [4:0]        reg_waddr_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              ready_o,
    output logic [4:0]        reg_waddr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_wen_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_END  = 2'd2;

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

    logic [1:0]        state;
    logic [1:0]        op_q;
    logic [4:0]        waddr_q;
    logic [DATA_W-1:0] quot_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W-1:0] rem_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              q_neg;
    logic              r_neg;

    logic              op_signed;
    logic              dvd_neg;
    logic              dvs_neg;
    logic [DATA_W-1:0] dvd_mag;
    logic [DATA_W-1:0] dvs_mag;
    logic              div_zero;
    logic              overflow;
    logic              early;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   rem_sub;
    logic              take;
    logic [DATA_W-1:0] q_res;
    logic [DATA_W-1:0] r_res;
    logic [DATA_W-1:0] result;

    always_comb begin
        op_signed = ~op_i[0];
        dvd_neg   = op_signed & dividend_i[DATA_W-1];
        dvs_neg   = op_signed & divisor_i[DATA_W-1];
        dvd_mag   = dvd_neg ? -dividend_i : dividend_i;
        dvs_mag   = dvs_neg ? -divisor_i : divisor_i;
        div_zero  = (divisor_i == '0);
        overflow  = op_signed & (dividend_i == MIN_NEG) & (divisor_i == ALL_ONES);
`ifdef EX_DIV_EARLY_OUT_EN
        early     = ~div_zero & (dvs_mag > dvd_mag);
`else
        early     = 1'b0;
`endif
    end

    // rem < divisor always holds, so the shifted remainder needs just one extra bit.
    always_comb begin
        rem_sh  = {rem_q, quot_q[DATA_W-1]};
        rem_sub = rem_sh - {1'b0, dvs_q};
        take    = (rem_sh >= {1'b0, dvs_q});
        q_res   = q_neg ? -quot_q : quot_q;
        r_res   = r_neg ? -rem_q : rem_q;
        result  = op_q[1] ? r_res : q_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            op_q        <= '0;
            waddr_q     <= '0;
            quot_q      <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            busy_o      <= 1'b0;
            ready_o     <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
            reg_wen_o   <= 1'b0;
        end else begin
            ready_o   <= 1'b0;
            reg_wen_o <= 1'b0;
            if (flush_i) begin
                state  <= S_IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_i) begin
                            op_q    <= op_i;
                            waddr_q <= reg_waddr_i;
                            busy_o  <= 1'b1;
                            cnt_q   <= '0;
                            dvs_q   <= dvs_mag;
                            // Special results are preloaded unsigned so END passes them through.
                            if (div_zero) begin
                                quot_q <= ALL_ONES;
                                rem_q  <= dividend_i;
                                q_neg  <= 1'b0;
                                r_neg  <= 1'b0;
                                state  <= S_END;
                            end else if (overflow) begin
                                quot_q <= MIN_NEG;
                                rem_q  <= '0;
                                q_neg  <= 1'b0;
                                r_neg  <= 1'b0;
                                state  <= S_END;
                            end else if (early) begin
                                quot_q <= '0;
                                rem_q  <= dvd_mag;
                                q_neg  <= dvd_neg ^ dvs_neg;
                                r_neg  <= dvd_neg;
                                state  <= S_END;
                            end else begin
                                quot_q <= dvd_mag;
                                rem_q  <= '0;
                                q_neg  <= dvd_neg ^ dvs_neg;
                                r_neg  <= dvd_neg;
                                state  <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        quot_q <= {quot_q[DATA_W-2:0], take};
                        rem_q  <= take ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state <= S_END;
                        end
                    end
                    S_END: begin
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                        state   <= S_IDLE;
                        if (waddr_q != 5'd0) begin
                            reg_wen_o   <= 1'b1;
                            reg_waddr_o <= waddr_q;
                            reg_wdata_o <= result;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - scoreboard bench for ex_div with directed vectors
module tb_ex_div;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
`ifdef EX_DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic        busy_o;
    logic        ready_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_wen_o;

    ex_div #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .reg_waddr_i (reg_waddr_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .ready_o     (ready_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_wen_o   (reg_wen_o)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [4:0]  waddr;
        logic        wen;
        int          lat;
        int          c0;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rdy_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the divider presents a result.
    always @(negedge clk) begin
        if (!rst) begin
            if (ready_o) rdy_cnt++;
            if (reg_wen_o && !ready_o) chk("wen_without_ready", 32'(reg_wen_o), 32'd0);
            if (ready_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 32'(ready_o), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, " wen"}, 32'(reg_wen_o), 32'(e.wen));
                    if (e.wen) begin
                        chk({e.name, " wdata"}, reg_wdata_o, e.data);
                        chk({e.name, " waddr"}, 32'(reg_waddr_o), 32'(e.waddr));
                    end
                    chk({e.name, " latency"}, 32'(cyc - e.c0), 32'(e.lat));
                    chk({e.name, " busy_at_ready"}, 32'(busy_o), 32'd0);
                end
            end
        end
    end

    task automatic issue(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wa,
                         input logic [31:0] exp, input int lat);
        exp_t e;
        int   n;
        logic busy_ok;
        @(negedge clk);
        start_i     = 1'b1;
        op_i        = op;
        dividend_i  = a;
        divisor_i   = b;
        reg_waddr_i = wa;
        e.name  = nm;
        e.data  = exp;
        e.waddr = wa;
        e.wen   = (wa != 5'd0);
        e.lat   = lat;
        e.c0    = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        busy_ok = 1'b1;
        n = 0;
        while (!ready_o && n < 60) begin
            if (!busy_o) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({nm, " busy_while_running"}, 32'(busy_ok), 32'd1);
        chk({nm, " completed"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        int base;
        rst = 1'b0; start_i = 1'b0; op_i = 2'b00; dividend_i = '0; divisor_i = '0;
        reg_waddr_i = '0; flush_i = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset busy",  32'(busy_o), 32'd0);
        chk("reset ready", 32'(ready_o), 32'd0);
        chk("reset wen",   32'(reg_wen_o), 32'd0);
        chk("reset waddr", 32'(reg_waddr_o), 32'd0);
        chk("reset wdata", reg_wdata_o, 32'd0);
        rst = 1'b0;

        issue("divu_100_7",   OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         33);
        issue("div_m7_2",     OP_DIV,  32'hFFFFFFF9,   32'd2,          5'd6,  32'hFFFFFFFD,   33);
        issue("rem_m7_2",     OP_REM,  32'hFFFFFFF9,   32'd2,          5'd7,  32'hFFFFFFFF,   33);
        issue("remu_big_2",   OP_REMU, 32'hFFFFFFF9,   32'd2,          5'd8,  32'd1,          33);
        issue("divu_big_2",   OP_DIVU, 32'hFFFFFFF9,   32'd2,          5'd9,  32'h7FFFFFFC,   33);
        issue("div_m100_7",   OP_DIV,  32'hFFFFFF9C,   32'd7,          5'd10, 32'hFFFFFFF2,   33);
        issue("rem_m100_7",   OP_REM,  32'hFFFFFF9C,   32'd7,          5'd11, 32'hFFFFFFFE,   33);
        issue("div_100_m7",   OP_DIV,  32'd100,        32'hFFFFFFF9,   5'd12, 32'hFFFFFFF2,   33);
        issue("rem_100_m7",   OP_REM,  32'd100,        32'hFFFFFFF9,   5'd13, 32'd2,          33);
        issue("div_by0",      OP_DIV,  32'd42,         32'd0,          5'd14, 32'hFFFFFFFF,   1);
        issue("divu_by0",     OP_DIVU, 32'd42,         32'd0,          5'd15, 32'hFFFFFFFF,   1);
        issue("rem_by0",      OP_REM,  32'd42,         32'd0,          5'd16, 32'd42,         1);
        issue("remu_by0",     OP_REMU, 32'd42,         32'd0,          5'd17, 32'd42,         1);
        issue("rem_m7_by0",   OP_REM,  32'hFFFFFFF9,   32'd0,          5'd18, 32'hFFFFFFF9,   1);
        issue("div_ovf",      OP_DIV,  32'h80000000,   32'hFFFFFFFF,   5'd19, 32'h80000000,   1);
        issue("rem_ovf",      OP_REM,  32'h80000000,   32'hFFFFFFFF,   5'd20, 32'd0,          1);
        issue("divu_3_10",    OP_DIVU, 32'd3,          32'd10,         5'd21, 32'd0,          EO_LAT);
        issue("div_m3_10",    OP_DIV,  32'hFFFFFFFD,   32'd10,         5'd22, 32'd0,          EO_LAT);
        issue("rem_m3_10",    OP_REM,  32'hFFFFFFFD,   32'd10,         5'd23, 32'hFFFFFFFD,   EO_LAT);
        issue("x0_dest",      OP_DIVU, 32'd10,         32'd2,          5'd0,  32'd5,          33);

        // Flush at CALC step 10 with start_i held high throughout.
        @(negedge clk);
        start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd1000; divisor_i = 32'd3; reg_waddr_i = 5'd4;
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        start_i = 1'b0;
        chk("flush busy_cleared", 32'(busy_o), 32'd0);
        chk("flush no_ready",     32'(ready_o), 32'd0);
        base = rdy_cnt;
        repeat (40) @(negedge clk);
        chk("flush no_pulse_after", 32'(rdy_cnt - base), 32'd0);
        issue("divu_9_3", OP_DIVU, 32'd9, 32'd3, 5'd3, 32'd3, 33);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd25;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst busy",  32'(busy_o), 32'd0);
        chk("async_rst ready", 32'(ready_o), 32'd0);
        chk("async_rst wen",   32'(reg_wen_o), 32'd0);
        chk("async_rst waddr", 32'(reg_waddr_o), 32'd0);
        chk("async_rst wdata", reg_wdata_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        base = rdy_cnt;
        repeat (40) @(negedge clk);
        chk("async_rst no_write", 32'(rdy_cnt - base), 32'd0);

        issue("post_rst_divu", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle RV32M divider in the EX stage.
- Executes DIV, DIVU, REM and REMU by radix-2 restoring shift-subtract.
- Writes its result straight into the register file write port (waddr/wdata/wen), upstream of the register file.
- Stalls the pipeline through busy_o while it iterates.

Parameters:
DATA_W, 32, operand/result width; the iteration count equals DATA_W.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start_i  input  1  request to begin a division; sampled only in IDLE.
op_i  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
dividend_i  input  DATA_W  rs1 value.
divisor_i  input  DATA_W  rs2 value.
reg_waddr_i  input  5  destination register for the result.
flush_i  input  1  abort any operation in progress.
busy_o  output  1  high from the accepting edge until the result edge, inclusive of CALC/END.
ready_o  output  1  one-cycle pulse when the result is valid.
reg_waddr_o  output  5  destination register to the register file.
reg_wdata_o  output  DATA_W  quotient or remainder.
reg_wen_o  output  1  register file write enable, one-cycle pulse.

Behaviour:
- Reset: asynchronous, active-high. While rst is high:
  - state=IDLE, all outputs 0.
  - Internal dividend, divisor, remainder and count registers are 0.
  - Reset during CALC/END discards the operation; no write is issued.
- States: IDLE, CALC, END.
- IDLE:
  - start_i=1 and flush_i=0 at edge E0 latches op_i, reg_waddr_i and operand magnitudes (signed ops use absolute values).
  - Records sign flags: quotient negative = signs differ; remainder negative = dividend negative.
  - Sets busy_o=1.
  - Special cases go to END at E0: divisor==0, or signed overflow (DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF).
  - Otherwise goes to CALC with count=0.
- CALC:
  - Each edge shifts {rem,quot} left one bit, then subtracts the divisor from rem if rem>=divisor and sets the quotient LSB.
  - After DATA_W steps (edges E0+1..E0+32) goes to END.
- END:
  - At the next edge: registers the sign-corrected result, pulses ready_o=1 and reg_wen_o for one cycle, clears busy_o, and returns to IDLE.
  - Sign correction: two's-complement negate where the sign flag is set.
- Latency:
  - Normal op: ready_o high in the cycle after edge E0+33.
  - Special case: ready_o high in the cycle after edge E0+1.
- Special results:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the original dividend.
  - Overflow: DIV gives 0x80000000; REM gives 0.
- reg_waddr_o/reg_wdata_o hold their last values when reg_wen_o=0.
- If the latched destination is x0: reg_wen_o stays 0, ready_o still pulses.
- start_i while busy_o=1: ignored, with no queueing.
- flush_i=1:
  - Any state returns to IDLE at the next edge with busy_o=0 and no write or ready pulse.
  - flush_i wins over start_i in the same cycle.
  - flush_i in the END cycle suppresses the write.
- After the result edge the block is back in IDLE, so start_i may be accepted at the edge immediately following the ready_o cycle.

Optional Feature:
- Macro: EX_DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, if the divisor magnitude is nonzero and greater than the dividend magnitude, the block goes straight to END with quotient=0 and remainder=dividend magnitude.
  - Result signs are applied as usual, so the result appears with special-case latency (1 edge).
- Undefined: such operands take the full DATA_W-step CALC path with identical results.

Test Plan:
- DIVU 100/7, waddr=5 -> ready_o and reg_wen_o high one cycle, 34 edges after start; reg_wdata_o=14, reg_waddr_o=5; busy_o high throughout.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). REMU 0xFFFFFFF9/2 -> 1.
- Divide by zero, dividend 42:
  - DIV/DIVU -> 0xFFFFFFFF after 1-edge latency.
  - REM/REMU -> 42.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; both with 1-edge latency.
- flush_i at CALC step 10 -> busy_o=0 next cycle, no reg_wen_o/ready_o pulse.
  - start_i held during busy is ignored.
  - A new DIVU 9/3 started after the flush -> 3.
- rst pulsed mid-CALC -> outputs 0 immediately (asynchronous), no write.
- Destination x0 -> ready_o pulses, reg_wen_o stays 0.
- With EX_DIV_EARLY_OUT_EN: DIVU 3/10 -> quotient 0 after 1-edge latency.
